noise_gate: RTL and testbench
=============================

# noise_gate

Per-sample downward noise gate for the signed audio stream, running at 11.29 MHz with one sample strobe per audio frame. It is the low-level counterpart to the peak limiter in the effects chain: the limiter clips samples above a ceiling, and this block mutes material below a floor. Gain changes are smoothed by an attack/hold/release state machine so gating produces no clicks. It sits in the per-track effects chain and is bypassable at runtime.

## Interface
Parameters:
- WIDTH, 16: sample width; samples are two's complement.
- GAIN_BITS, 8: gain fraction bits; unity gain is 2^GAIN_BITS = 256.
- ATTACK_STEP, 64: gain increment per sample in ATTACK; range 1..256.
- RELEASE_STEP, 16: gain decrement per sample in RELEASE; range 1..256.
- HOLD_SAMPLES, 4: count of below-threshold samples held at full gain before release; must be ≥1.

Ports:
- clk_in, input, 1: system clock (11.29 MHz).
- rst_in, input, 1: synchronous, active-low reset.
- gate_enable, input, 1: 1 = gate active; 0 = bypass.
- threshold, input, WIDTH: unsigned magnitude floor.
- sample_valid_in, input, 1: one-cycle strobe; data_dry is valid this cycle.
- data_dry, input, WIDTH: signed input sample.
- data_wet, output, WIDTH: signed gated sample.
- sample_valid_out, output, 1: one-cycle strobe; data_wet is updated this cycle.

## Operation
- Everything advances only on cycles where sample_valid_in=1. Strobes may arrive back-to-back or at any spacing.
- Magnitude: mag = |data_dry|, saturated so that -2^(WIDTH-1) maps to 2^(WIDTH-1)-1. A sample is "above" when mag ≥ threshold (unsigned compare). With threshold=0, every sample is above.
- State: gain register, 0..256, 9 bits. States are CLOSED, ATTACK, OPEN, HOLD, RELEASE. Transitions and gain updates are evaluated per sample:
  - CLOSED (gain 0): above → ATTACK, gain = min(ATTACK_STEP, 256); below → stay.
  - ATTACK: gain = min(gain+ATTACK_STEP, 256); → OPEN when the result is 256. Below samples do not abort an attack.
  - OPEN (gain 256): below → HOLD, hold_cnt = HOLD_SAMPLES-1, gain unchanged; above → stay.
  - HOLD (gain 256): above → OPEN; below with hold_cnt>0 → hold_cnt--; below with hold_cnt=0 → RELEASE, gain = max(256-RELEASE_STEP, 0).
  - RELEASE: above → ATTACK, gain = min(gain+ATTACK_STEP, 256); below → gain = max(gain-RELEASE_STEP, 0), → CLOSED when the result is 0.
- The gain applied to a sample is the gain after that sample's update.
- Output arithmetic: product = signed(sample) × unsigned(gain), WIDTH+10 bits; data_wet = product >>> GAIN_BITS (arithmetic shift, floor toward -inf). No saturation is needed because gain ≤ 256. Gain 256 is exact identity; gain 0 gives 0.
- Bypass: when gate_enable=0 on a strobe cycle, data_wet = data_dry with the same latency, and the FSM is forced to OPEN with gain=256 and hold_cnt=0. Re-enabling therefore starts open.
- gate_enable and threshold are sampled only on strobe cycles. A change takes effect at the next strobe.

## Timing
- Pipeline: strobe at cycle N; at N+1 the sample register, gain and state are updated; at N+2 data_wet is registered and sample_valid_out is high for exactly one cycle.
- Latency is 2 cycles in both gated and bypass mode. Throughput is one sample per cycle.
- data_wet holds its value between strobes.
- Reset (rst_in=0 at a clk_in edge) values: data_wet=0, sample_valid_out=0, state=CLOSED, gain=0, hold_cnt=0, and all pipeline valids cleared.
- Reset mid-stream: samples in flight are dropped and produce no sample_valid_out. The first strobe after reset is processed from CLOSED.
- A strobe coinciding with reset is ignored.

## Test plan
- Reset then silence: threshold=1000, enable=1, 10 samples of 500 → every data_wet=0, one sample_valid_out per strobe, each exactly 2 cycles after its input strobe.
- Attack ramp: after CLOSED, samples of +1000 with threshold=1000 → outputs 250, 500, 750, 1000, 1000, … (gains 64, 128, 192, 256).
- Hold and release: from OPEN, samples of +512 with threshold=1000 → 512 ×4 (hold), then 480, 448, … each step -32 (gain -16), down to 0 after 16 release samples; state ends CLOSED.
- Re-trigger during release: mid-release at gain 128, an input of -2000 → gain 192, output -1500. The next -2000 → gain 256, output -2000.
- Saturated magnitude and rounding: threshold=32767, input -32768 → above; at gain 64 output -8192. Input -1 at gain 128 → output -1 (floor).
- Bypass and back-to-back strobes: enable=0, strobes on consecutive cycles with 7, -3, 0 → outputs 7, -3, 0 on consecutive cycles, 2-cycle latency. Then enable=1 with a below-threshold sample → HOLD behaviour starting from gain 256.

Source files
------------

// File: rtl/noise_gate.sv
`default_nettype none
// ============================================================================
//  Module   : noise_gate
//  Purpose  : Per-sample downward noise gate for a signed audio stream.
//             Samples whose magnitude falls below a programmable floor are
//             faded out; samples at or above it are faded back in. Gain
//             moves through CLOSED/ATTACK/OPEN/HOLD/RELEASE so that gating
//             never produces an abrupt step. Runtime bypass passes samples
//             through untouched with the same latency.
//  Ports    : clk_in           - system clock
//             rst_in           - synchronous reset, active low
//             gate_enable      - 1 = gate active, 0 = bypass
//             threshold        - unsigned magnitude floor
//             sample_valid_in  - one-cycle strobe qualifying data_dry
//             data_dry         - signed input sample
//             data_wet         - signed gated sample (held between strobes)
//             sample_valid_out - one-cycle strobe, data_wet updated
//  Latency  : 2 clock cycles, one sample per cycle throughput
//  Revision : 1.0 - initial release
// ============================================================================
module noise_gate #(
  parameter int WIDTH        = 16,
  parameter int GAIN_BITS    = 8,
  parameter int ATTACK_STEP  = 64,
  parameter int RELEASE_STEP = 16,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             gate_enable,
  input  logic [WIDTH-1:0] threshold,
  input  logic             sample_valid_in,
  input  logic [WIDTH-1:0] data_dry,
  output logic [WIDTH-1:0] data_wet,
  output logic             sample_valid_out
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  // Gain spans 0..2^GAIN_BITS inclusive, so it needs one bit above the fraction.
  localparam int GW = GAIN_BITS + 1;
  // One more bit again so gain +/- step never wraps before clamping.
  localparam int SW = GAIN_BITS + 2;
  // Full product of a WIDTH-bit signed sample and a GW-bit unsigned gain.
  localparam int PW = WIDTH + GAIN_BITS + 2;

  localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

  localparam int UNITY_I         = 2 ** GAIN_BITS;
  localparam int FIRST_GAIN_I    = (ATTACK_STEP > UNITY_I) ? UNITY_I : ATTACK_STEP;
  localparam int RELEASE_START_I = (RELEASE_STEP > UNITY_I) ? 0 : (UNITY_I - RELEASE_STEP);

  localparam logic [GW-1:0]     UNITY         = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [SW-1:0]     UNITY_EXT     = {2'b01, {GAIN_BITS{1'b0}}};
  localparam logic [GW-1:0]     GAIN_ZERO     = '0;
  localparam logic [GW-1:0]     FIRST_GAIN    = GW'(FIRST_GAIN_I);
  localparam logic [GW-1:0]     RELEASE_START = GW'(RELEASE_START_I);
  localparam logic [SW-1:0]     ATTACK_INC    = SW'(ATTACK_STEP);
  localparam logic [SW-1:0]     RELEASE_DEC   = SW'(RELEASE_STEP);
  localparam logic [HOLD_W-1:0] HOLD_INIT     = HOLD_W'(HOLD_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO     = '0;
  localparam logic [HOLD_W-1:0] HOLD_ONE      = HOLD_W'(1);

  localparam logic [WIDTH-1:0]  ONE_W   = WIDTH'(1);
  localparam logic [WIDTH-1:0]  MAG_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] ST_CLOSED  = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [GW-1:0]     gain;
  logic [GW-1:0]     gain_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  logic [WIDTH-1:0]  neg_dry;
  logic [WIDTH-1:0]  mag;
  logic              above;

  logic [SW-1:0]     gain_ext;
  logic [SW-1:0]     gain_up;
  logic [SW-1:0]     gain_dn;
  logic [GW-1:0]     attack_gain;
  logic [GW-1:0]     release_gain;

  // Stage 1: sample aligned with the gain register it will be scaled by.
  logic [WIDTH-1:0]  sample_q;
  logic              bypass_q;
  logic              valid_q;

  logic [PW-1:0]     sample_ext;
  logic [PW-1:0]     gain_mul;
  logic [PW-1:0]     product;
  logic [WIDTH-1:0]  wet_nxt;

  logic              unused_bits;

  // --------------------------------------------------------------------------
  // Saturated magnitude and threshold compare
  // --------------------------------------------------------------------------
  assign neg_dry = (~data_dry) + ONE_W;

  always_comb begin
    mag = data_dry;
    if (data_dry[WIDTH-1]) begin
      // Negating the most negative value wraps back to itself (MSB still set);
      // clamp it to the largest positive magnitude instead.
      mag = neg_dry[WIDTH-1] ? MAG_MAX : neg_dry;
    end
  end

  assign above = (mag >= threshold);

  // --------------------------------------------------------------------------
  // Clamped gain ramps
  // --------------------------------------------------------------------------
  assign gain_ext = {1'b0, gain};
  assign gain_up  = gain_ext + ATTACK_INC;
  assign gain_dn  = gain_ext - RELEASE_DEC;

  assign attack_gain  = (gain_up >= UNITY_EXT) ? UNITY : gain_up[GW-1:0];
  assign release_gain = (gain_ext <= RELEASE_DEC) ? GAIN_ZERO : gain_dn[GW-1:0];

  // --------------------------------------------------------------------------
  // FSM process 1: state register (state, gain, hold counter)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= ST_CLOSED;
      gain     <= GAIN_ZERO;
      hold_cnt <= HOLD_ZERO;
    end else begin
      state    <= state_nxt;
      gain     <= gain_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state and gain update, evaluated only on strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    gain_nxt  = gain;
    hold_nxt  = hold_cnt;

    if (sample_valid_in) begin
      if (!gate_enable) begin
        // Bypass parks the gate fully open so re-enabling never fades in.
        state_nxt = ST_OPEN;
        gain_nxt  = UNITY;
        hold_nxt  = HOLD_ZERO;
      end else begin
        case (state)
          ST_CLOSED: begin
            if (above) begin
              state_nxt = ST_ATTACK;
              gain_nxt  = FIRST_GAIN;
            end
          end

          ST_ATTACK: begin
            // An attack always runs to completion regardless of level.
            gain_nxt = attack_gain;
            if (attack_gain == UNITY) begin
              state_nxt = ST_OPEN;
            end
          end

          ST_OPEN: begin
            if (!above) begin
              state_nxt = ST_HOLD;
              hold_nxt  = HOLD_INIT;
            end
          end

          ST_HOLD: begin
            if (above) begin
              state_nxt = ST_OPEN;
            end else if (hold_cnt != HOLD_ZERO) begin
              hold_nxt = hold_cnt - HOLD_ONE;
            end else begin
              state_nxt = ST_RELEASE;
              gain_nxt  = RELEASE_START;
            end
          end

          ST_RELEASE: begin
            if (above) begin
              state_nxt = ST_ATTACK;
              gain_nxt  = attack_gain;
            end else begin
              gain_nxt = release_gain;
              if (release_gain == GAIN_ZERO) begin
                state_nxt = ST_CLOSED;
              end
            end
          end

          default: begin
            state_nxt = ST_CLOSED;
            gain_nxt  = GAIN_ZERO;
            hold_nxt  = HOLD_ZERO;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1 pipeline: capture the sample alongside its gain update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sample_q <= '0;
      bypass_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= sample_valid_in;
      if (sample_valid_in) begin
        sample_q <= data_dry;
        bypass_q <= ~gate_enable;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 3: output arithmetic
  // --------------------------------------------------------------------------
  // Signed sample times zero-extended gain; taking the bits above the fraction
  // is an arithmetic shift, i.e. floor toward -inf. Gain never exceeds unity,
  // so the selected field cannot overflow.
  assign sample_ext = {{(GAIN_BITS+2){sample_q[WIDTH-1]}}, sample_q};
  assign gain_mul   = {{(WIDTH+1){1'b0}}, gain};
  assign product    = $signed(sample_ext) * $signed(gain_mul);

  always_comb begin
    wet_nxt = product[GAIN_BITS +: WIDTH];
    if (bypass_q) begin
      wet_nxt = sample_q;
    end
  end

  assign unused_bits = ^{product[GAIN_BITS-1:0], product[PW-1:WIDTH+GAIN_BITS], gain_dn[SW-1]};

  // --------------------------------------------------------------------------
  // Stage 2 pipeline: registered output, held between strobes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      data_wet         <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      sample_valid_out <= valid_q;
      if (valid_q) begin
        data_wet <= wet_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noise_gate.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noise_gate
//  Purpose  : Self-checking bench for noise_gate. A behavioural model keeps
//             the gate's gain/phase as plain integers and queues each expected
//             output with the cycle it must appear on; a compare process
//             checks every cycle. Directed phases pin the model with
//             hand-computed values, followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noise_gate;

  localparam int WIDTH = 16;
  localparam int AS    = 64;
  localparam int RS    = 16;
  localparam int HS    = 4;
  localparam int UNITY = 256;

  logic             clk_in = 1'b0;
  logic             rst_in = 1'b0;
  logic             gate_enable = 1'b0;
  logic [WIDTH-1:0] threshold = '0;
  logic             sample_valid_in = 1'b0;
  logic [WIDTH-1:0] data_dry = '0;
  logic [WIDTH-1:0] data_wet;
  logic             sample_valid_out;

  noise_gate #(
    .WIDTH(WIDTH), .GAIN_BITS(8), .ATTACK_STEP(AS),
    .RELEASE_STEP(RS), .HOLD_SAMPLES(HS)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .gate_enable(gate_enable),
    .threshold(threshold),
    .sample_valid_in(sample_valid_in),
    .data_dry(data_dry),
    .data_wet(data_wet),
    .sample_valid_out(sample_valid_out)
  );

  always #5 clk_in = ~clk_in;

  // --------------------------------------------------------------------------
  // Model
  // --------------------------------------------------------------------------
  typedef enum int {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} mode_t;
  typedef struct { int val; int due; } exp_t;

  mode_t m_mode;
  int    m_gain;
  int    m_hold;
  exp_t  exp_q[$];
  int    obs[$];
  int    edge_cnt = 0;
  int    last_wet = 0;
  bit    seen_reset = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  function automatic int min_i(int a, int b); return (a < b) ? a : b; endfunction
  function automatic int max_i(int a, int b); return (a > b) ? a : b; endfunction

  function automatic int floor_div(int p);
    int q;
    q = p / UNITY;
    if ((p % UNITY) != 0 && p < 0) q = q - 1;
    return q;
  endfunction

  function automatic int magnitude(int d);
    int m;
    m = (d < 0) ? -d : d;
    if (m > 32767) m = 32767;
    return m;
  endfunction

  // Applies one strobe to the model and returns the expected output value.
  function automatic int model_step(int d, bit en, int thr);
    bit above;
    if (!en) begin
      m_mode = M_OPEN; m_gain = UNITY; m_hold = 0;
      return d;
    end
    above = magnitude(d) >= thr;
    case (m_mode)
      M_CLOSED:  if (above) begin m_mode = M_ATTACK; m_gain = min_i(AS, UNITY); end
      M_ATTACK:  begin
                   m_gain = min_i(m_gain + AS, UNITY);
                   if (m_gain == UNITY) m_mode = M_OPEN;
                 end
      M_OPEN:    if (!above) begin m_mode = M_HOLD; m_hold = HS - 1; end
      M_HOLD:    if (above) m_mode = M_OPEN;
                 else if (m_hold > 0) m_hold = m_hold - 1;
                 else begin m_mode = M_RELEASE; m_gain = max_i(UNITY - RS, 0); end
      default:   if (above) begin m_mode = M_ATTACK; m_gain = min_i(m_gain + AS, UNITY); end
                 else begin
                   m_gain = max_i(m_gain - RS, 0);
                   if (m_gain == 0) m_mode = M_CLOSED;
                 end
    endcase
    return floor_div(d * m_gain);
  endfunction

  // Model advances on the same edges the DUT samples its inputs.
  always @(posedge clk_in) begin
    exp_t e;
    edge_cnt = edge_cnt + 1;
    if (!rst_in) begin
      m_mode = M_CLOSED; m_gain = 0; m_hold = 0;
      exp_q.delete();
      last_wet = 0;
      seen_reset = 1;
    end else if (sample_valid_in) begin
      e.val = model_step(int'($signed(data_dry)), gate_enable, int'(threshold));
      e.due = edge_cnt + 1;
      exp_q.push_back(e);
    end
  end

  // --------------------------------------------------------------------------
  // Compare process: every cycle, away from the active edge
  // --------------------------------------------------------------------------
  bit               due_now;
  exp_t             cur;
  logic [WIDTH-1:0] exp_bits;

  always @(negedge clk_in) begin
    if (seen_reset) begin
      due_now = (exp_q.size() > 0) && (exp_q[0].due == edge_cnt);
      n_cmp = n_cmp + 1;
      if (sample_valid_out !== due_now) begin
        n_err = n_err + 1;
        $display("FAIL valid @edge %0d: got %b expected %b", edge_cnt, sample_valid_out, due_now);
      end
      if (due_now) begin
        cur = exp_q.pop_front();
        exp_bits = cur.val[WIDTH-1:0];
        last_wet = cur.val;
      end else begin
        exp_bits = last_wet[WIDTH-1:0];
      end
      n_cmp = n_cmp + 1;
      if (data_wet !== exp_bits) begin
        n_err = n_err + 1;
        $display("FAIL %s @edge %0d: got %0d expected %0d", due_now ? "data_wet" : "data_hold",
                 edge_cnt, $signed(data_wet), $signed(exp_bits));
      end
      if (sample_valid_out === 1'b1) obs.push_back(int'($signed(data_wet)));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic send(input int d, input bit en, input int thr, input int gap);
    data_dry        = d[WIDTH-1:0];
    gate_enable     = en;
    threshold       = thr[WIDTH-1:0];
    sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    repeat (gap) begin @(posedge clk_in); #1; end
  endtask

  task automatic drain();
    repeat (4) begin @(posedge clk_in); #1; end
  endtask

  task automatic check_lit(input string name, input int idx, input int expv);
    n_cmp = n_cmp + 1;
    if (idx >= obs.size()) begin
      n_err = n_err + 1;
      $display("FAIL %s: got no output (index %0d) expected %0d", name, idx, expv);
    end else if (obs[idx] != expv) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", name, obs[idx], expv);
    end
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  int base;
  int d_r, thr_r, sel;
  bit en_r;

  initial begin
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Silence below floor stays muted.
    base = obs.size();
    for (int i = 0; i < 10; i++) send(500, 1, 1000, 1);
    drain();
    check_lit("silence_first", base, 0);
    check_lit("silence_last", base + 9, 0);

    // Attack ramp from CLOSED.
    base = obs.size();
    for (int i = 0; i < 6; i++) send(1000, 1, 1000, 1);
    drain();
    check_lit("attack_g64", base, 250);
    check_lit("attack_g128", base + 1, 500);
    check_lit("attack_g192", base + 2, 750);
    check_lit("attack_g256", base + 3, 1000);
    check_lit("open_steady", base + 5, 1000);

    // Hold then release down to closed.
    base = obs.size();
    for (int i = 0; i < 21; i++) send(512, 1, 1000, 1);
    drain();
    check_lit("hold_first", base, 512);
    check_lit("hold_last", base + 3, 512);
    check_lit("release_first", base + 4, 480);
    check_lit("release_second", base + 5, 448);
    check_lit("release_end", base + 19, 0);
    check_lit("closed_after", base + 20, 0);

    // Re-trigger during release at gain 128.
    base = obs.size();
    for (int i = 0; i < 4; i++)  send(1000, 1, 1000, 1);
    for (int i = 0; i < 12; i++) send(512, 1, 1000, 1);
    send(-2000, 1, 1000, 1);
    send(-2000, 1, 1000, 1);
    drain();
    check_lit("release_g128", base + 15, 256);
    check_lit("retrigger_g192", base + 16, -1500);
    check_lit("retrigger_g256", base + 17, -2000);

    // Saturated magnitude and floor rounding.
    base = obs.size();
    for (int i = 0; i < 20; i++) send(0, 1, 32767, 1);
    send(-32768, 1, 32767, 1);
    send(-1, 1, 32767, 1);
    drain();
    check_lit("sat_mag_g64", base + 20, -8192);
    check_lit("floor_neg1", base + 21, -1);

    // Bypass back-to-back, then re-enable starting open.
    base = obs.size();
    send(7, 0, 1000, 0);
    send(-3, 0, 1000, 0);
    send(0, 0, 1000, 3);
    for (int i = 0; i < 5; i++) send(100, 1, 1000, 1);
    drain();
    check_lit("bypass_7", base, 7);
    check_lit("bypass_m3", base + 1, -3);
    check_lit("bypass_0", base + 2, 0);
    check_lit("reenable_hold", base + 3, 100);
    check_lit("reenable_release", base + 7, 93);

    // Reset mid-stream and strobe coinciding with reset.
    base = obs.size();
    send(1000, 1, 0, 0);
    rst_in = 1'b0;
    sample_valid_in = 1'b1;
    @(posedge clk_in); #1;
    sample_valid_in = 1'b0;
    rst_in = 1'b1;
    drain();
    n_cmp = n_cmp + 1;
    if (obs.size() != base) begin
      n_err = n_err + 1;
      $display("FAIL reset_drop: got %0d outputs expected 0", obs.size() - base);
    end
    send(1000, 1, 1000, 1);
    drain();
    check_lit("after_reset_closed", base, 250);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      d_r = -32768;
      else if (sel == 1) d_r = $urandom_range(0, 65535) - 32768;
      else               d_r = $urandom_range(0, 8000) - 4000;
      sel = $urandom_range(0, 9);
      if (sel == 0)      thr_r = 0;
      else if (sel == 1) thr_r = $urandom_range(0, 65535);
      else               thr_r = $urandom_range(0, 3000);
      en_r = ($urandom_range(0, 11) != 0);
      send(d_r, en_r, thr_r, $urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
      end
    end
    drain();

    n_cmp = n_cmp + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL pending_outputs: got %0d outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
